// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit for the execute stage.
// Radix-2 shift-add multiply and restoring divide, 32 iterations each.
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] b_q;
    logic [CNT_W-1:0] cnt;
    logic             neg_q;

    logic             is_div;
    logic             a_signed;
    logic             b_signed;
    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             neg_d;
    logic             div_zero;
    logic             div_ovf;
    logic [WIDTH-1:0] fast_res;

    always_comb begin
        is_div   = op[2];
        a_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        b_signed = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        sa       = a_signed & src_a[WIDTH-1];
        sb       = b_signed & src_b[WIDTH-1];
        abs_a    = sa ? (~src_a + 1'b1) : src_a;
        abs_b    = sb ? (~src_b + 1'b1) : src_b;
        // Remainder takes the dividend's sign; everything else the xor.
        neg_d    = (is_div & op[1]) ? sa : (sa ^ sb);
        div_zero = is_div && (src_b == '0);
        div_ovf  = is_div && !op[0] && (src_a == MIN_NEG) && (&src_b);
        fast_res = '0;
        if (div_zero) begin
            fast_res = op[1] ? src_a : '1;
        end else if (div_ovf) begin
            fast_res = op[1] ? '0 : MIN_NEG;
        end
    end

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;

    always_comb begin
        sum    = {1'b0, hi_q} + ({(WIDTH+1){lo_q[0]}} & {1'b0, b_q});
        rem_sh = {hi_q, lo_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, b_q};
        ge     = ~diff[WIDTH];
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (op_q[2]) begin
            hi_d = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], ge};
        end else begin
            hi_d = sum[WIDTH:1];
            lo_d = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_n;
    logic [WIDTH-1:0]   quo_n;
    logic [WIDTH-1:0]   rem_n;
    logic [WIDTH-1:0]   fix_res;

    always_comb begin
        prod    = {hi_q, lo_q};
        prod_n  = neg_q ? (~prod + 1'b1) : prod;
        quo_n   = neg_q ? (~lo_q + 1'b1) : lo_q;
        rem_n   = neg_q ? (~hi_q + 1'b1) : hi_q;
        fix_res = '0;
        unique case (1'b1)
            (op_q == 3'd0): fix_res = prod_n[WIDTH-1:0];
            (!op_q[2] && op_q != 3'd0): fix_res = prod_n[2*WIDTH-1:WIDTH];
            (op_q[2] && !op_q[1]): fix_res = quo_n;
            (op_q[2] && op_q[1]): fix_res = rem_n;
            default: fix_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            op_q   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            result <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        cnt   <= '0;
                        neg_q <= neg_d;
                        hi_q  <= '0;
                        lo_q  <= abs_a;
                        b_q   <= abs_b;
                        if (div_zero || div_ovf) begin
                            result <= fast_res;
                            state  <= S_DONE;
                        end else begin
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    hi_q <= hi_d;
                    lo_q <= lo_d;
                    cnt  <= cnt + 1'b1;
                    if (cnt == '1) state <= S_FIX;
                end
                S_FIX: begin
                    result <= fix_res;
                    state  <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy  = (state == S_CALC) || (state == S_FIX);
    assign done  = (state == S_DONE);
    assign stall = ((state == S_IDLE) && start && !flush) || busy;

endmodule
